// File: rtl/ga_fitness_unit.sv
// ga_fitness_unit: two-lane fitness responder returning |chrom - TARGET|^3 per lane.
// Each lane squares then cubes the distance with an LSB-first shift-add multiplier.
module ga_fitness_unit #(
    parameter int                     CHROM_WIDTH   = 16,
    parameter int                     FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3,
    parameter logic [CHROM_WIDTH-1:0] TARGET        = 16'h1234
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ff_enable,
    input  logic [CHROM_WIDTH-1:0]   ff_chrom1,
    input  logic [CHROM_WIDTH-1:0]   ff_chrom2,
    output logic                     ff_ready,
    output logic                     ff_valid,
    output logic [FITNESS_WIDTH-1:0] ff_fit1,
    output logic [FITNESS_WIDTH-1:0] ff_fit2
);
    localparam int L  = CHROM_WIDTH + 1;
    localparam int AW = 3 * L;
    localparam int CW = $clog2(L);

    typedef enum logic [2:0] {IDLE, DIFF, SQR, CUBE, DONE} state_t;

    state_t                   r_state, w_next;
    logic [CW-1:0]            r_cnt;
    logic                     r_valid;
    logic                     w_ready, w_accept, w_last, w_mul;
    logic [CHROM_WIDTH-1:0]   w_chrom [2];
    logic [CHROM_WIDTH-1:0]   r_chrom [2];
    logic [L-1:0]             r_a     [2];
    logic [L-1:0]             r_mp    [2];
    logic [AW-1:0]            r_mc    [2];
    logic [AW-1:0]            r_acc   [2];
    logic [FITNESS_WIDTH-1:0] r_fit   [2];
    logic [L-1:0]             w_d     [2];
    logic [L-1:0]             w_abs   [2];
    logic [AW-1:0]            w_sum   [2];

    assign w_chrom[0] = ff_chrom1;
    assign w_chrom[1] = ff_chrom2;
    assign w_ready    = (r_state == IDLE) || (r_state == DONE);
    assign w_accept   = ff_enable && w_ready;
    assign w_last     = r_cnt == CW'(CHROM_WIDTH);
    assign w_mul      = (r_state == SQR) || (r_state == CUBE);
    assign ff_ready   = w_ready;
    assign ff_valid   = r_valid;
    assign ff_fit1    = r_fit[0];
    assign ff_fit2    = r_fit[1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = ff_enable ? DIFF : IDLE;
            DIFF:       w_next = SQR;
            SQR:        w_next = w_last ? CUBE : SQR;
            CUBE:       w_next = w_last ? DONE : CUBE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_mul && !w_last) ? r_cnt + 1'b1 : '0;
            r_valid <= (r_state == CUBE) && w_last;
        end
    end

    // Distance is formed one bit wider than the chromosome so underflow yields a true magnitude.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_d[i]   = {1'b0, r_chrom[i]} - {1'b0, TARGET};
            w_abs[i] = w_d[i][L-1] ? -w_d[i] : w_d[i];
            w_sum[i] = r_acc[i] + (r_mp[i][0] ? r_mc[i] : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_chrom[i] <= '0;
                r_a[i]     <= '0;
                r_mp[i]    <= '0;
                r_mc[i]    <= '0;
                r_acc[i]   <= '0;
                r_fit[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_accept)
                    r_chrom[i] <= w_chrom[i];
                if (r_state == DIFF) begin
                    r_a[i]   <= w_abs[i];
                    r_mp[i]  <= w_abs[i];
                    r_mc[i]  <= AW'(w_abs[i]);
                    r_acc[i] <= '0;
                end else if (w_mul) begin
                    // The square's final sum becomes the multiplicand of the cube pass.
                    r_mp[i]  <= w_last ? r_a[i] : r_mp[i] >> 1;
                    r_mc[i]  <= w_last ? w_sum[i] : r_mc[i] << 1;
                    r_acc[i] <= w_last ? '0 : w_sum[i];
                    if (r_state == CUBE && w_last)
                        r_fit[i] <= FITNESS_WIDTH'(w_sum[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_ga_fitness_unit.sv
// tb_ga_fitness_unit: directed and random checks of two ga_fitness_unit instances (TARGET 0x1234 and 0).
module tb_ga_fitness_unit;
    localparam logic [15:0] T0 = 16'h1234;
    localparam logic [15:0] T1 = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ff_enable = 1'b0;
    logic [15:0] ff_chrom1 = '0;
    logic [15:0] ff_chrom2 = '0;
    logic        rdy0, val0, rdy1, val1;
    logic [50:0] f10, f20, f11, f21;
    logic [50:0] e10 = '0, e20 = '0, e11 = '0, e21 = '0;
    int          passes = 0;
    int          total = 0;

    always #5 clk = ~clk;

    ga_fitness_unit u0 (
        .clk(clk), .reset(reset), .ff_enable(ff_enable), .ff_chrom1(ff_chrom1), .ff_chrom2(ff_chrom2),
        .ff_ready(rdy0), .ff_valid(val0), .ff_fit1(f10), .ff_fit2(f20)
    );

    ga_fitness_unit #(.TARGET(T1)) u1 (
        .clk(clk), .reset(reset), .ff_enable(ff_enable), .ff_chrom1(ff_chrom1), .ff_chrom2(ff_chrom2),
        .ff_ready(rdy1), .ff_valid(val1), .ff_fit1(f11), .ff_fit2(f21)
    );

    function automatic logic [50:0] model(input logic [15:0] c, input logic [15:0] t);
        logic [63:0] d;
        d = (c >= t) ? 64'(c - t) : 64'(t - c);
        return 51'(d * d * d);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting edge; returns in the cycle where ff_valid is high.
    task automatic await_result(input logic [15:0] c1, input logic [15:0] c2);
        int n = 0;
        bit busy_ok = 1'b1;
        bit stable_ok = 1'b1;
        while (!val0 && n < 100) begin
            if (rdy0 || rdy1 || val1) busy_ok = 1'b0;
            if (f10 !== e10 || f20 !== e20 || f11 !== e11 || f21 !== e21) stable_ok = 1'b0;
            if (n == 3) begin
                ff_chrom1 = 16'($urandom);
                ff_chrom2 = 16'($urandom);
            end
            tick();
            n++;
        end
        chk("latency", 64'(n), 35);
        chk("busy_not_ready", 64'(busy_ok), 1);
        chk("fit_stable", 64'(stable_ok), 1);
        e10 = model(c1, T0);
        e20 = model(c2, T0);
        e11 = model(c1, T1);
        e21 = model(c2, T1);
        chk("valid_t0", 64'(val0), 1);
        chk("valid_t1", 64'(val1), 1);
        chk("fit1_t0", 64'(f10), 64'(e10));
        chk("fit2_t0", 64'(f20), 64'(e20));
        chk("fit1_t1", 64'(f11), 64'(e11));
        chk("fit2_t1", 64'(f21), 64'(e21));
    endtask

    task automatic req(input logic [15:0] c1, input logic [15:0] c2);
        ff_chrom1 = c1;
        ff_chrom2 = c2;
        ff_enable = 1'b1;
        tick();
        ff_enable = 1'b0;
        await_result(c1, c2);
        tick();
        chk("valid_one_cycle", 64'(val0), 0);
        chk("ready_after", 64'(rdy0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] p1 [4];
        logic [15:0] p2 [4];
        bit          quiet;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", 64'(rdy0 & rdy1), 1);
            chk("idle_valid", 64'(val0 | val1), 0);
            chk("idle_fits", 64'(f10 | f20 | f11 | f21), 0);
        end
        req(16'h1234, 16'h1237);
        chk("exact_target", 64'(f10), 0);
        chk("cube_of_3", 64'(f20), 27);
        req(16'h0000, 16'h1231);
        chk("underflow_big", 64'(f10), 64'd101194696000);
        chk("underflow_small", 64'(f20), 27);
        req(16'hFFFF, 16'hFFFF);
        chk("max_mag", 64'(f11), 64'd281462092005375);
        chk("lanes_equal", 64'(f10), 64'(f20));
        for (int i = 0; i < 6; i++) req(16'($urandom), 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            p1[i] = 16'($urandom);
            p2[i] = 16'($urandom);
        end
        ff_chrom1 = p1[0];
        ff_chrom2 = p2[0];
        ff_enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            await_result(p1[k], p2[k]);
            if (k < 3) begin
                ff_chrom1 = p1[k+1];
                ff_chrom2 = p2[k+1];
            end else ff_enable = 1'b0;
            tick();
        end
        chk("b2b_end_valid", 64'(val0), 0);
        ff_chrom1 = 16'h4321;
        ff_chrom2 = 16'h0007;
        ff_enable = 1'b1;
        tick();
        ff_enable = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ready", 64'(rdy0 & rdy1), 1);
        chk("rst_valid", 64'(val0 | val1), 0);
        chk("rst_fits", 64'(f10 | f20 | f11 | f21), 0);
        e10 = '0;
        e20 = '0;
        e11 = '0;
        e21 = '0;
        repeat (2) tick();
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (val0 || val1 || !rdy0 || (f10 | f20 | f11 | f21) != 0) quiet = 1'b0;
        end
        chk("rst_discard", 64'(quiet), 1);
        req(16'h1237, 16'h1234);
        chk("post_rst_fit1", 64'(f10), 27);
        chk("post_rst_fit2", 64'(f20), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
